min_max_finder_n: RTL and testbench



---
 rtl/min_max_pkg.sv | 20 ++
 rtl/min_max_cmp.sv | 23 ++
 rtl/min_max_finder_n.sv | 140 ++++++++++++++
 tb/tb_min_max_finder_n.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/min_max_pkg.sv
// Shared types and helpers for the sequential min/max finder.
// The state encoding is one-hot so each bit maps directly onto a state flag output.
package min_max_pkg;

    typedef enum logic [2:0] {
        INIT = 3'b001,
        COMP = 3'b010,
        DONE = 3'b100
    } state_t;

    localparam int ST_INIT_BIT = 0;
    localparam int ST_COMP_BIT = 1;
    localparam int ST_DONE_BIT = 2;

    // Width of an index that can address n operands.
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/min_max_cmp.sv
// Combinational magnitude compare of a against b.
// The compare is signed or unsigned depending on signed_mode.
module min_max_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_mode,
    output logic         gt,
    output logic         lt
);

    always_comb begin
        if (signed_mode) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
    end

endmodule

// File: rtl/min_max_finder_n.sv
// Sequential extremum finder: latches N operands on start, scans one per clock,
// then holds max/min, their indices and the scan cycle count until acknowledged.
module min_max_finder_n
    import min_max_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 8,
    parameter int IW = idx_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            ack,
    input  logic            signed_mode,
    input  logic [N*W-1:0]  data_in,
    output logic [W-1:0]    max,
    output logic [W-1:0]    min,
    output logic [IW-1:0]   max_idx,
    output logic [IW-1:0]   min_idx,
    output logic [IW:0]     cycles,
    output logic            Done,
    output logic            Qi,
    output logic            Qc,
    output logic            Qd
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_ops [N];
    logic           r_signed;
    logic [W-1:0]   r_max;
    logic [W-1:0]   r_min;
    logic [IW-1:0]  r_max_idx;
    logic [IW-1:0]  r_min_idx;
    logic [IW-1:0]  r_idx;
    logic [IW:0]    r_cycles;

    logic [W-1:0]   w_cur;
    logic           w_last;
    logic           w_load;
    logic           w_gt_max;
    logic           w_lt_min;
    logic           w_unused_max_lt;
    logic           w_unused_min_gt;

    assign w_cur  = r_ops[r_idx];
    assign w_last = (r_idx == LAST_IDX);
    assign w_load = (r_state == INIT) && start;

    min_max_cmp #(.W(W)) u_cmp_max (
        .a           (w_cur),
        .b           (r_max),
        .signed_mode (r_signed),
        .gt          (w_gt_max),
        .lt          (w_unused_max_lt)
    );

    min_max_cmp #(.W(W)) u_cmp_min (
        .a           (w_cur),
        .b           (r_min),
        .signed_mode (r_signed),
        .gt          (w_unused_min_gt),
        .lt          (w_lt_min)
    );

    // Handshake: start is honoured only in INIT and ack only in DONE; Done stays
    // high with results frozen until ack, and ack beats a simultaneous start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            INIT:    if (start)  w_next = COMP;
            COMP:    if (w_last) w_next = DONE;
            DONE:    if (ack)    w_next = INIT;
            default: w_next = INIT;
        endcase
    end

    // Operand capture needs no reset: it is always loaded before it is read.
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int k = 0; k < N; k++) begin
                r_ops[k] <= data_in[k*W +: W];
            end
            r_signed <= signed_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_max     <= '0;
            r_min     <= '0;
            r_max_idx <= '0;
            r_min_idx <= '0;
            r_idx     <= '0;
            r_cycles  <= '0;
        end else if (w_load) begin
            r_max     <= data_in[W-1:0];
            r_min     <= data_in[W-1:0];
            r_max_idx <= '0;
            r_min_idx <= '0;
            r_idx     <= IW'(1);
            r_cycles  <= '0;
        end else if (r_state == COMP) begin
            // Strict compares keep the earliest index on ties.
            if (w_gt_max) begin
                r_max     <= w_cur;
                r_max_idx <= r_idx;
            end
            if (w_lt_min) begin
                r_min     <= w_cur;
                r_min_idx <= r_idx;
            end
            r_cycles <= r_cycles + 1'b1;
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign max     = r_max;
    assign min     = r_min;
    assign max_idx = r_max_idx;
    assign min_idx = r_min_idx;
    assign cycles  = r_cycles;
    assign Qi      = r_state[ST_INIT_BIT];
    assign Qc      = r_state[ST_COMP_BIT];
    assign Qd      = r_state[ST_DONE_BIT];
    assign Done    = Qd;

endmodule

// File: tb/tb_min_max_finder_n.sv
// Bench for min_max_finder_n: an N=4 and an N=2 instance, directed and random scans,
// expected results queued by the drivers and checked by monitors on each Done rise.
module tb_min_max_finder_n;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int N2  = 2;
    localparam int IW2 = 1;
    localparam int EW  = 2*W + 2*IW + IW + 1;
    localparam int EW2 = 2*W + 2*IW2 + IW2 + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- DUT N=4 ----------------
    logic            start, ack, sm;
    logic [N*W-1:0]  data_in;
    logic [W-1:0]    mx, mn;
    logic [IW-1:0]   mxi, mni;
    logic [IW:0]     cyc;
    logic            done, qi, qc, qd;

    min_max_finder_n #(.W(W), .N(N)) dut4 (
        .clk(clk), .reset(reset), .start(start), .ack(ack), .signed_mode(sm),
        .data_in(data_in), .max(mx), .min(mn), .max_idx(mxi), .min_idx(mni),
        .cycles(cyc), .Done(done), .Qi(qi), .Qc(qc), .Qd(qd)
    );

    // ---------------- DUT N=2 ----------------
    logic            start2, ack2, sm2;
    logic [N2*W-1:0] data_in2;
    logic [W-1:0]    mx2, mn2;
    logic [IW2-1:0]  mxi2, mni2;
    logic [IW2:0]    cyc2;
    logic            done2, qi2, qc2, qd2;

    min_max_finder_n #(.W(W), .N(N2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .ack(ack2), .signed_mode(sm2),
        .data_in(data_in2), .max(mx2), .min(mn2), .max_idx(mxi2), .min_idx(mni2),
        .cycles(cyc2), .Done(done2), .Qi(qi2), .Qc(qc2), .Qd(qd2)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0]  exp_q[$];
    logic [EW2-1:0] exp2_q[$];
    int start_q[$];
    int start2_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: map each operand to an integer value, find the extreme values,
    // then the lowest index holding each extreme.
    task automatic model(input logic [31:0] d, input bit s, input int n,
                         output logic [7:0] rmx, output logic [7:0] rmn,
                         output int rmi, output int rni);
        int val[4];
        int hi, lo;
        for (int k = 0; k < n; k++) begin
            if (s) val[k] = int'($signed(d[k*8 +: 8]));
            else   val[k] = int'({24'd0, d[k*8 +: 8]});
        end
        hi = val[0];
        lo = val[0];
        for (int k = 1; k < n; k++) begin
            if (val[k] > hi) hi = val[k];
            if (val[k] < lo) lo = val[k];
        end
        rmi = -1;
        rni = -1;
        for (int k = 0; k < n; k++) begin
            if (rmi < 0 && val[k] == hi) rmi = k;
            if (rni < 0 && val[k] == lo) rni = k;
        end
        rmx = d[rmi*8 +: 8];
        rmn = d[rni*8 +: 8];
    endtask

    function automatic logic [EW-1:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                            input int ai, input int bi);
        return {a, b, 2'(ai), 2'(bi), 3'd3};
    endfunction

    function automatic logic [EW2-1:0] pack2(input logic [7:0] a, input logic [7:0] b,
                                             input int ai, input int bi);
        return {a, b, 1'(ai), 1'(bi), 2'd1};
    endfunction

    function automatic logic [31:0] ops4(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // ---------------- monitors ----------------
    logic done_d = 1'b0;
    logic done2_d = 1'b0;
    logic [EW-1:0]  m_e;
    logic [EW2-1:0] m_e2;
    int m_s, m_s2;

    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL n4_unexpected_done: got Done=1 required no pending scan");
            end else begin
                m_e = exp_q.pop_front();
                m_s = start_q.pop_front();
                check("n4_result", 64'({mx, mn, mxi, mni, cyc}), 64'(m_e));
                check("n4_latency", 64'(cyc_cnt - m_s), 64'(N - 1));
            end
        end
        done_d <= done;
    end

    always @(negedge clk) begin
        if (done2 && !done2_d) begin
            if (exp2_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL n2_unexpected_done: got Done=1 required no pending scan");
            end else begin
                m_e2 = exp2_q.pop_front();
                m_s2 = start2_q.pop_front();
                check("n2_result", 64'({mx2, mn2, mxi2, mni2, cyc2}), 64'(m_e2));
                check("n2_latency", 64'(cyc_cnt - m_s2), 64'(N2 - 1));
            end
        end
        done2_d <= done2;
    end

    // ---------------- drivers ----------------
    task automatic run4(input logic [31:0] d, input bit s, input logic [EW-1:0] e,
                        input bit scramble, input bit do_ack);
        int t;
        @(negedge clk);
        data_in = d;
        sm      = s;
        start   = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        start_q.push_back(cyc_cnt);
        start = 1'b0;
        if (scramble) begin
            data_in = $urandom;
            sm      = ~s;
        end
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            if (scramble) data_in = $urandom;
            t++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL n4_timeout: got no Done required Done within 20 clocks");
        end
        if (do_ack) begin
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
        end
    endtask

    task automatic run2(input logic [15:0] d, input bit s, input logic [EW2-1:0] e);
        int t;
        @(negedge clk);
        data_in2 = d;
        sm2      = s;
        start2   = 1'b1;
        @(posedge clk);
        #1;
        exp2_q.push_back(e);
        start2_q.push_back(cyc_cnt);
        start2 = 1'b0;
        t = 0;
        while (!done2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!done2) begin
            n_tests++;
            n_fail++;
            $display("FAIL n2_timeout: got no Done required Done within 20 clocks");
        end
        ack2 = 1'b1;
        @(negedge clk);
        ack2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] rmx, rmn;
        int rmi, rni;
        logic [31:0] d;
        logic [EW-1:0] hold_exp;
        bit s;

        start = 0; ack = 0; sm = 0; data_in = '0;
        start2 = 0; ack2 = 0; sm2 = 0; data_in2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", 64'({qi, qc, qd, done}), 64'(4'b1000));
        check("reset_outputs", 64'({mx, mn, mxi, mni, cyc}), 64'(0));
        check("reset_flags_n2", 64'({qi2, qc2, qd2, done2}), 64'(4'b1000));
        reset = 1'b0;

        // Directed N=4 scans
        run4(ops4(3, 7, 1, 7), 0, pack4(7, 1, 1, 2), 0, 1);
        run4(ops4(8'h80, 8'h7F, 8'hFF, 8'h00), 1, pack4(8'h7F, 8'h80, 1, 0), 0, 1);
        run4(ops4(8'h80, 8'h7F, 8'hFF, 8'h00), 0, pack4(8'hFF, 8'h00, 2, 3), 0, 1);
        run4(ops4(5, 5, 5, 5), 0, pack4(5, 5, 0, 0), 0, 1);

        // Reset on the second COMP clock
        @(negedge clk);
        data_in = ops4(1, 2, 3, 4);
        sm = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_comp_state", 64'(qc), 64'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_flags", 64'({qi, qc, qd, done}), 64'(4'b1000));
        check("abort_outputs", 64'({mx, mn, mxi, mni, cyc}), 64'(0));
        run4(ops4(2, 9, 4, 6), 0, pack4(9, 2, 1, 0), 0, 1);

        // Input isolation: data and mode change during COMP
        run4(ops4(8'h20, 8'h90, 8'h11, 8'h55), 0, pack4(8'h90, 8'h11, 1, 2), 1, 1);

        // Hold in DONE with ack low while start pulses
        hold_exp = pack4(8'h40, 8'h05, 1, 2);
        run4(ops4(8'h10, 8'h40, 8'h05, 8'h40), 0, hold_exp, 0, 0);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            @(negedge clk);
            check("hold_state", 64'({qi, qc, qd, done}), 64'(4'b0011));
            check("hold_results", 64'({mx, mn, mxi, mni, cyc}), 64'(hold_exp));
        end
        start = 1'b1;
        ack   = 1'b1;
        @(posedge clk);
        #1;
        check("ack_wins", 64'({qi, qc, qd, done}), 64'(4'b1000));
        start = 1'b0;
        ack   = 1'b0;
        @(posedge clk);
        #1;
        check("no_new_scan", 64'({qi, qc, qd}), 64'(3'b100));
        check("init_holds_results", 64'({mx, mn, mxi, mni, cyc}), 64'(hold_exp));

        // Random scans, wide values and tie-heavy small values
        for (int i = 0; i < 24; i++) begin
            if (i < 12) d = $urandom;
            else d = ops4(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                          8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            s = 1'($urandom_range(0, 1));
            model(d, s, N, rmx, rmn, rmi, rni);
            run4(d, s, pack4(rmx, rmn, rmi, rni), 0, 1);
        end

        // N=2 instance
        run2({8'd4, 8'd9}, 0, pack2(9, 4, 0, 1));
        run2({8'h01, 8'hFF}, 1, pack2(8'h01, 8'hFF, 1, 0));
        run2({8'h01, 8'hFF}, 0, pack2(8'hFF, 8'h01, 0, 1));
        for (int i = 0; i < 8; i++) begin
            d = {16'd0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            s = 1'($urandom_range(0, 1));
            model(d, s, N2, rmx, rmn, rmi, rni);
            run2(d[15:0], s, pack2(rmx, rmn, rmi, rni));
        end

        repeat (4) @(negedge clk);
        check("n4_queue_drained", 64'(exp_q.size()), 64'(0));
        check("n2_queue_drained", 64'(exp2_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
